// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// Memory access plus MEM/WB pipeline register for a 5-stage RV32 core.
// Stores write an internal word-wide data memory, which has per-byte lane
// enables. Loads read that memory synchronously on the same edge that
// registers the EX/MEM slot. Load data is extracted combinationally from the
// registered raw word. The stage never stalls.
//
// Ports
//   clk              : single clock, rising edge
//   rst              : asynchronous, active-low reset
//   valid_i_mem      : EX/MEM slot holds a real instruction
//   pc_next_i_mem    : PC+4 of the instruction (jump link value)
//   alu_i_mem        : ALU result / effective address
//   data_i_mem       : store data (rs2)
//   wbaddr_now_i_mem : destination register rd
//   instr_i_mem      : raw instruction word
//   wen_o_wb         : register-file write enable
//   wbaddr_o_wb      : write-back register index
//   wbdata_o_wb      : selected write-back data
//   instr_o_wb       : instruction in the WB slot (NOP for bubbles)
//   misalign_o_wb    : misaligned load/store flag for the WB-slot instruction
// -----------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int DMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i_mem,
   input  logic [31:0] pc_next_i_mem,
   input  logic [31:0] alu_i_mem,
   input  logic [31:0] data_i_mem,
   input  logic [4:0]  wbaddr_now_i_mem,
   input  logic [31:0] instr_i_mem,
   output logic        wen_o_wb,
   output logic [4:0]  wbaddr_o_wb,
   output logic [31:0] wbdata_o_wb,
   output logic [31:0] instr_o_wb,
   output logic        misalign_o_wb
);

   localparam int          AW  = $clog2(DMEM_WORDS);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {K_NONE, K_LOAD, K_JUMP, K_ALU} kind_e;

   logic [31:0] mem [DMEM_WORDS];

   logic [AW-1:0] idx;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic [1:0]    alo;
   logic          is_load, is_store, is_jump, is_alu;
   logic          ld_mis, st_mis;
   logic          mem_we;
   logic [3:0]    be;
   logic [31:0]   wdata;

   kind_e         kind_d, kind_q;
   logic          wen_d, wen_q;
   logic          mis_d, mis_q;
   logic [4:0]    wbaddr_d, wbaddr_q;
   logic [31:0]   instr_d, instr_q;
   logic [31:0]   rdata_d, rdata_q;
   logic [31:0]   pc_d, pc_q;
   logic [31:0]   alu_d, alu_q;
   logic [2:0]    f3_d, f3_q;
   logic [1:0]    alo_d, alo_q;

   // Pick the addressed byte or halfword out of the raw word and extend it.
   // Unsupported funct3 values yield 0.
   function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  a);
      logic signed [7:0]  bs;
      logic signed [15:0] hs;
      logic signed [31:0] r;
      bs = w[{a, 3'b000} +: 8];
      hs = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  r = bs;
         3'b100:  r = {24'h0, bs};
         3'b001:  r = hs;
         3'b101:  r = {16'h0, hs};
         3'b010:  r = w;
         default: r = '0;
      endcase
      return r;
   endfunction

   always_comb begin
      idx      = alu_i_mem[AW+1:2];
      opcode   = instr_i_mem[6:0];
      funct3   = instr_i_mem[14:12];
      alo      = alu_i_mem[1:0];
      is_load  = (opcode == 7'b0000011);
      is_store = (opcode == 7'b0100011);
      is_jump  = (opcode == 7'b1101111) || (opcode == 7'b1100111);
      is_alu   = (opcode == 7'b0110011) || (opcode == 7'b0010011) ||
                 (opcode == 7'b0110111) || (opcode == 7'b0010111);

      ld_mis = is_load && ((((funct3 == 3'b001) || (funct3 == 3'b101)) && alo[0]) ||
                           ((funct3 == 3'b010) && (alo != 2'b00)));
      st_mis = is_store && (((funct3 == 3'b001) && alo[0]) ||
                            ((funct3 == 3'b010) && (alo != 2'b00)));

      // Store lanes: data is replicated so every enabled lane sees its bytes.
      be    = 4'b0000;
      wdata = data_i_mem;
      case (funct3)
         3'b000: begin
            be    = 4'b0001 << alo;
            wdata = {4{data_i_mem[7:0]}};
         end
         3'b001: begin
            be    = alo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{data_i_mem[15:0]}};
         end
         3'b010: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      mem_we = valid_i_mem && is_store && !st_mis;

      kind_d = K_NONE;
      if (valid_i_mem) begin
         if (is_load)      kind_d = K_LOAD;
         else if (is_jump) kind_d = K_JUMP;
         else if (is_alu)  kind_d = K_ALU;
      end
      wen_d    = (kind_d != K_NONE) && (wbaddr_now_i_mem != 5'd0);
      mis_d    = valid_i_mem && (ld_mis || st_mis);
      wbaddr_d = wbaddr_now_i_mem;
      instr_d  = valid_i_mem ? instr_i_mem : NOP;

      rdata_d = mem[idx];
      pc_d    = pc_next_i_mem;
      alu_d   = alu_i_mem;
      f3_d    = funct3;
      alo_d   = alo;
   end

   // Memory array: not reset, writes suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (rst && mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // MEM/WB boundary: control fields reset asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kind_q   <= K_NONE;
         wen_q    <= 1'b0;
         mis_q    <= 1'b0;
         wbaddr_q <= 5'd0;
         instr_q  <= NOP;
      end else begin
         kind_q   <= kind_d;
         wen_q    <= wen_d;
         mis_q    <= mis_d;
         wbaddr_q <= wbaddr_d;
         instr_q  <= instr_d;
      end
   end

   // MEM/WB boundary: data fields, qualified by kind_q so no reset is needed.
   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      f3_q    <= f3_d;
      alo_q   <= alo_d;
   end

   always_comb begin
      case (kind_q)
         K_LOAD:  wbdata_o_wb = mis_q ? 32'h0 : load_extract(rdata_q, f3_q, alo_q);
         K_JUMP:  wbdata_o_wb = pc_q;
         K_ALU:   wbdata_o_wb = alu_q;
         default: wbdata_o_wb = 32'h0;
      endcase
      wen_o_wb      = wen_q;
      wbaddr_o_wb   = wbaddr_q;
      instr_o_wb    = instr_q;
      misalign_o_wb = mis_q;
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_R = 7'b0110011, OP_I = 7'b0010011,
                          OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_SYS = 7'b1110011;

   logic        clk, rst;
   logic        valid_i_mem;
   logic [31:0] pc_next_i_mem, alu_i_mem, data_i_mem, instr_i_mem;
   logic [4:0]  wbaddr_now_i_mem;
   logic        wen_o_wb, misalign_o_wb;
   logic [4:0]  wbaddr_o_wb;
   logic [31:0] wbdata_o_wb, instr_o_wb;

   int checks = 0;
   int errors = 0;

   // Byte-addressed reference memory (1 KiB, matching 256 words).
   logic [7:0] mb [1024];

   typedef struct packed {
      logic        wen;
      logic [31:0] data;
      logic        mis;
      logic [31:0] instr;
   } exp_t;

   mem_wb_stage #(.DMEM_WORDS(256)) dut (
      .clk(clk), .rst(rst), .valid_i_mem(valid_i_mem), .pc_next_i_mem(pc_next_i_mem),
      .alu_i_mem(alu_i_mem), .data_i_mem(data_i_mem), .wbaddr_now_i_mem(wbaddr_now_i_mem),
      .instr_i_mem(instr_i_mem), .wen_o_wb(wen_o_wb), .wbaddr_o_wb(wbaddr_o_wb),
      .wbdata_o_wb(wbdata_o_wb), .instr_o_wb(instr_o_wb), .misalign_o_wb(misalign_o_wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
      return {17'h0, f3, rd, op};
   endfunction

   function automatic int access_size(input logic [2:0] f3);
      return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
   endfunction

   // Expected WB-slot result computed from the instruction's architectural meaning.
   function automatic exp_t model(input logic v, input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] pcn, input logic [4:0] rd);
      exp_t e;
      int ba, sz;
      logic [31:0] val;
      logic [6:0] op;
      e.wen = 1'b0; e.data = 32'h0; e.mis = 1'b0; e.instr = v ? ins : NOP;
      if (!v) return e;
      op = ins[6:0];
      ba = int'(a[9:0]);
      sz = access_size(ins[14:12]);
      if (op == OP_LD) begin
         e.wen = (rd != 0);
         if (ba % sz != 0) e.mis = 1'b1;
         else begin
            val = 32'h0;
            for (int k = 0; k < sz; k++) val = val | (32'(mb[ba+k]) << (8*k));
            if (!ins[14] && sz < 4 && val[8*sz-1]) val = val | ~((32'h1 << (8*sz)) - 32'h1);
            e.data = val;
         end
      end else if (op == OP_ST) begin
         e.mis = (ba % sz != 0);
      end else if (op == OP_JAL || op == OP_JALR) begin
         e.wen = (rd != 0); e.data = pcn;
      end else if (op == OP_R || op == OP_I || op == OP_LUI || op == OP_AUIPC) begin
         e.wen = (rd != 0); e.data = a;
      end
      return e;
   endfunction

   task automatic model_store(input logic v, input logic [31:0] ins, input logic [31:0] a,
                              input logic [31:0] d);
      int ba, sz;
      if (!v || ins[6:0] != OP_ST) return;
      ba = int'(a[9:0]);
      sz = access_size(ins[14:12]);
      if (ba % sz != 0) return;
      for (int k = 0; k < sz; k++) mb[ba+k] = d[8*k +: 8];
   endtask

   // Present one EX/MEM slot, advance one edge, return the expected WB result.
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] pcn, input logic [4:0] rd,
                       output exp_t e);
      valid_i_mem = v; instr_i_mem = ins; alu_i_mem = a; data_i_mem = d;
      pc_next_i_mem = pcn; wbaddr_now_i_mem = rd;
      e = model(v, ins, a, pcn, rd);
      model_store(v, ins, a, d);
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      valid_i_mem = 1'b0; instr_i_mem = NOP; alu_i_mem = 0; data_i_mem = 0;
      pc_next_i_mem = 0; wbaddr_now_i_mem = 0;
      #2 rst = 1'b0;
      #1;
      checks++; if (wen_o_wb !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", wen_o_wb); end
      checks++; if (wbaddr_o_wb !== 5'd0) begin errors++; $display("FAIL reset_wbaddr got %0d exp 0", wbaddr_o_wb); end
      checks++; if (wbdata_o_wb !== 32'h0) begin errors++; $display("FAIL reset_wbdata got %h exp 0", wbdata_o_wb); end
      checks++; if (misalign_o_wb !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", misalign_o_wb); end
      checks++; if (instr_o_wb !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instr_o_wb, NOP); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_directed;
      exp_t e;
      step(1, mk(OP_ST, 3'b010, 0), 32'h10, 32'hDEADBEEF, 0, 0, e);
      checks++; if (wen_o_wb !== 1'b0 || misalign_o_wb !== 1'b0) begin errors++; $display("FAIL sw_flags got wen=%b mis=%b exp 0 0", wen_o_wb, misalign_o_wb); end
      step(1, mk(OP_LD, 3'b010, 3), 32'h10, 0, 0, 3, e);
      checks++; if (wen_o_wb !== 1'b1 || wbaddr_o_wb !== 5'd3) begin errors++; $display("FAIL lw_wen got wen=%b addr=%0d exp 1 3", wen_o_wb, wbaddr_o_wb); end
      checks++; if (wbdata_o_wb !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", wbdata_o_wb); end
      step(1, mk(OP_LD, 3'b000, 4), 32'h13, 0, 0, 4, e);
      checks++; if (wbdata_o_wb !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb got %h exp ffffffde", wbdata_o_wb); end
      step(1, mk(OP_LD, 3'b100, 4), 32'h13, 0, 0, 4, e);
      checks++; if (wbdata_o_wb !== 32'h000000DE) begin errors++; $display("FAIL lbu got %h exp 000000de", wbdata_o_wb); end
      step(1, mk(OP_LD, 3'b001, 4), 32'h12, 0, 0, 4, e);
      checks++; if (wbdata_o_wb !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh got %h exp ffffdead", wbdata_o_wb); end
      step(1, mk(OP_LD, 3'b101, 4), 32'h10, 0, 0, 4, e);
      checks++; if (wbdata_o_wb !== 32'h0000BEEF) begin errors++; $display("FAIL lhu got %h exp 0000beef", wbdata_o_wb); end
      step(1, mk(OP_ST, 3'b000, 0), 32'h11, 32'h00000055, 0, 0, e);
      step(1, mk(OP_LD, 3'b010, 6), 32'h10, 0, 0, 6, e);
      checks++; if (wbdata_o_wb !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_lw got %h exp dead55ef", wbdata_o_wb); end
      step(1, mk(OP_ST, 3'b010, 0), 32'h12, 32'h12345678, 0, 0, e);
      checks++; if (misalign_o_wb !== 1'b1) begin errors++; $display("FAIL sw_mis got %b exp 1", misalign_o_wb); end
      step(1, mk(OP_LD, 3'b010, 6), 32'h10, 0, 0, 6, e);
      checks++; if (wbdata_o_wb !== 32'hDEAD55EF || misalign_o_wb !== 1'b0) begin errors++; $display("FAIL sw_mis_nowrite got %h mis=%b exp dead55ef 0", wbdata_o_wb, misalign_o_wb); end
      step(1, mk(OP_LD, 3'b010, 5), 32'h11, 0, 0, 5, e);
      checks++; if (wbdata_o_wb !== 32'h0 || misalign_o_wb !== 1'b1 || wen_o_wb !== 1'b1) begin errors++; $display("FAIL lw_mis got %h mis=%b wen=%b exp 0 1 1", wbdata_o_wb, misalign_o_wb, wen_o_wb); end
      step(1, mk(OP_JAL, 3'b000, 1), 32'h0, 0, 32'h104, 1, e);
      checks++; if (wbdata_o_wb !== 32'h104 || wen_o_wb !== 1'b1) begin errors++; $display("FAIL jal got %h wen=%b exp 104 1", wbdata_o_wb, wen_o_wb); end
      step(1, mk(OP_R, 3'b000, 0), 32'h55, 0, 0, 0, e);
      checks++; if (wen_o_wb !== 1'b0) begin errors++; $display("FAIL alu_rd0 got wen=%b exp 0", wen_o_wb); end
      step(0, mk(OP_R, 3'b000, 9), 32'h55, 0, 0, 9, e);
      checks++; if (wen_o_wb !== 1'b0 || instr_o_wb !== NOP || misalign_o_wb !== 1'b0) begin errors++; $display("FAIL bubble got wen=%b instr=%h mis=%b exp 0 %h 0", wen_o_wb, instr_o_wb, misalign_o_wb, NOP); end
   endtask

   task automatic test_reset_midop;
      exp_t e;
      step(1, mk(OP_LD, 3'b010, 7), 32'h10, 0, 0, 7, e);
      checks++; if (wen_o_wb !== 1'b1 || wbdata_o_wb !== 32'hDEAD55EF) begin errors++; $display("FAIL pre_rst got wen=%b %h exp 1 dead55ef", wen_o_wb, wbdata_o_wb); end
      valid_i_mem = 1; instr_i_mem = mk(OP_ST, 3'b010, 0); alu_i_mem = 32'h10;
      data_i_mem = 32'hCAFEF00D; wbaddr_now_i_mem = 0;
      #3 rst = 1'b0;
      #1;
      checks++; if (wen_o_wb !== 1'b0 || wbaddr_o_wb !== 5'd0 || wbdata_o_wb !== 32'h0 || misalign_o_wb !== 1'b0 || instr_o_wb !== NOP)
         begin errors++; $display("FAIL async_rst got wen=%b addr=%0d data=%h mis=%b instr=%h exp 0 0 0 0 %h", wen_o_wb, wbaddr_o_wb, wbdata_o_wb, misalign_o_wb, instr_o_wb, NOP); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (wen_o_wb !== 1'b0 || instr_o_wb !== NOP) begin errors++; $display("FAIL rst_hold got wen=%b instr=%h exp 0 %h", wen_o_wb, instr_o_wb, NOP); end
      valid_i_mem = 0;
      rst = 1'b1;
      step(0, NOP, 0, 0, 0, 0, e);
      step(1, mk(OP_LD, 3'b010, 7), 32'h10, 0, 0, 7, e);
      checks++; if (wbdata_o_wb !== 32'hDEAD55EF) begin errors++; $display("FAIL rst_store_dropped got %h exp dead55ef", wbdata_o_wb); end
   endtask

   task automatic test_random;
      exp_t e;
      logic [2:0] lf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [6:0] aop [4] = '{OP_R, OP_I, OP_LUI, OP_AUIPC};
      for (int w = 0; w < 256; w++)
         step(1, mk(OP_ST, 3'b010, 0), 32'(w*4), $urandom, 0, 0, e);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ins, a, d, pcn;
         logic [4:0] rd;
         logic v;
         int sel;
         sel = $urandom_range(0, 9);
         rd  = 5'($urandom_range(0, 31));
         a   = $urandom; d = $urandom; pcn = $urandom;
         v   = (sel != 9);
         case (sel)
            0, 1, 2: ins = mk(OP_LD, lf3[$urandom_range(0, 4)], rd);
            3, 4, 5: ins = mk(OP_ST, 3'($urandom_range(0, 2)), rd);
            6:       ins = mk($urandom_range(0, 1) ? OP_JAL : OP_JALR, 3'b000, rd);
            7:       ins = mk(aop[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), rd);
            default: ins = mk(OP_SYS, 3'b000, rd);
         endcase
         step(v, ins, a, d, pcn, rd, e);
         checks++; if (wen_o_wb !== e.wen) begin errors++; $display("FAIL rand_wen[%0d] got %b exp %b", i, wen_o_wb, e.wen); end
         checks++; if (wbdata_o_wb !== e.data) begin errors++; $display("FAIL rand_data[%0d] got %h exp %h", i, wbdata_o_wb, e.data); end
         checks++; if (misalign_o_wb !== e.mis) begin errors++; $display("FAIL rand_mis[%0d] got %b exp %b", i, misalign_o_wb, e.mis); end
         checks++; if (instr_o_wb !== e.instr) begin errors++; $display("FAIL rand_instr[%0d] got %h exp %h", i, instr_o_wb, e.instr); end
         if (e.wen) begin
            checks++; if (wbaddr_o_wb !== rd) begin errors++; $display("FAIL rand_wbaddr[%0d] got %0d exp %0d", i, wbaddr_o_wb, rd); end
         end
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         logic [2:0] sf3;
         a   = $urandom;
         sf3 = 3'($urandom_range(0, 2));
         a   = (sf3 == 3'b010) ? {a[31:2], 2'b00} : (sf3 == 3'b001) ? {a[31:1], 1'b0} : a;
         step(1, mk(OP_ST, sf3, 0), a, $urandom, 0, 0, e);
         step(1, mk(OP_LD, 3'b010, 8), {a[31:2], 2'b00}, 0, 0, 8, e);
         checks++; if (wbdata_o_wb !== e.data) begin errors++; $display("FAIL b2b[%0d] got %h exp %h", i, wbdata_o_wb, e.data); end
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_reset_midop;
      test_random;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
